// File: rtl/tile_writeback.sv
// Snapshots a ROWS x COLS matrix and streams it to BRAM as LANES-wide words with backpressure.
// Optional column-major traversal is built only when TILE_WB_COLMAJOR_EN is defined.
module tile_writeback #(
  parameter int unsigned ROWS       = 32,
  parameter int unsigned COLS       = 32,
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_valid,
  input  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] i_matrix,
  input  logic [ADDR_WIDTH-1:0]                    i_base_addr,
`ifdef TILE_WB_COLMAJOR_EN
  input  logic                                     i_col_major,
`endif
  output logic                                     o_ready,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_wr_en,
  input  logic                                     i_wr_ready,
  output logic [ADDR_WIDTH-1:0]                    o_wr_addr,
  output logic [LANES*BIT_WIDTH-1:0]               o_wr_data
);

  localparam int unsigned BEATS  = ROWS * COLS / LANES;
  localparam int unsigned WORD_W = LANES * BIT_WIDTH;
  localparam int unsigned KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] LastBeat = KW'(BEATS - 1);

  typedef logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] matrix_t;
  typedef logic [BEATS-1:0][WORD_W-1:0]              words_t;
  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  // Row-major order matches the packed layout, so word k is just the k-th WORD_W slice.
  function automatic logic [WORD_W-1:0] word_rm(input matrix_t m, input logic [KW-1:0] k);
    words_t w;
    w = m;
    return w[k];
  endfunction

`ifdef TILE_WB_COLMAJOR_EN
  localparam int unsigned RG = ROWS / LANES;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  // LANES divides ROWS, so all lanes of a word share one column and take consecutive rows.
  function automatic logic [WORD_W-1:0] word_cm(input matrix_t m, input logic [KW-1:0] k);
    logic [WORD_W-1:0] w;
    int unsigned       kk, col, r0;
    w   = '0;
    kk  = 32'(k);
    col = kk / RG;
    r0  = (kk % RG) * LANES;
    for (int unsigned l = 0; l < LANES; l++) begin
      w[l*BIT_WIDTH +: BIT_WIDTH] = m[RW'(r0 + l)][CW'(col)];
    end
    return w;
  endfunction
`endif

  state_e             state_q;
  matrix_t            snap_q;
  logic [KW-1:0]      k_q;
  logic [KW-1:0]      k_next;
  logic [WORD_W-1:0]  first_word;
  logic [WORD_W-1:0]  next_word;
`ifdef TILE_WB_COLMAJOR_EN
  logic               col_major_q;
`endif

  assign k_next = k_q + KW'(1);

  always_comb begin
    first_word = word_rm(i_matrix, '0);
    next_word  = word_rm(snap_q, k_next);
`ifdef TILE_WB_COLMAJOR_EN
    if (i_col_major) first_word = word_cm(i_matrix, '0);
    if (col_major_q) next_word  = word_cm(snap_q, k_next);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      snap_q      <= '0;
      k_q         <= '0;
      o_ready     <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
`ifdef TILE_WB_COLMAJOR_EN
      col_major_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            state_q     <= StWrite;
            snap_q      <= i_matrix;
            k_q         <= '0;
            o_ready     <= 1'b0;
            o_busy      <= 1'b1;
            o_wr_en     <= 1'b1;
            o_wr_addr   <= i_base_addr;
            o_wr_data   <= first_word;
`ifdef TILE_WB_COLMAJOR_EN
            col_major_q <= i_col_major;
`endif
          end
        end
        StWrite: begin
          if (i_wr_ready) begin
            if (k_q == LastBeat) begin
              state_q <= StDone;
              o_wr_en <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              k_q       <= k_next;
              o_wr_addr <= o_wr_addr + ADDR_WIDTH'(1);
              o_wr_data <= next_word;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
